gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port q, output, WIDTH bits, the Gray-coded count, driven directly from a register.
REQ-005 The block SHALL contain an internal register named b, WIDTH bits, holding the binary count, readable by hierarchical reference (DUT.b).
REQ-006 The block SHALL have no other ports, enable, load or direction control.

Function
REQ-007 On every rising clk edge with rst_n high, b SHALL become b+1 modulo 2^WIDTH.
REQ-008 q SHALL be registered and updated on the same edge as b, so that after every edge q == b XOR (b >> 1), with b being the new binary value.
REQ-009 q and b SHALL never disagree at any observation point after the clock edge: zero cycles of latency between b and q, and no combinational glitch path to q.
REQ-010 Wrap-around: when b is all-ones (4'b1111), the next edge SHALL give b = 0 and q = 0 (q goes 4'b1000 -> 4'b0000).
REQ-011 Between consecutive counts, including at wrap-around, q SHALL change in exactly one bit position.
REQ-012 The full period SHALL be 2^WIDTH clock edges (16 for WIDTH=4), with each Gray code appearing exactly once per period.
REQ-013 For WIDTH=4 the q sequence from reset SHALL be 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then repeat.

Reset
REQ-014 When rst_n goes low, b and q SHALL clear to 0 immediately, without waiting for a clk edge.
REQ-015 While rst_n is low, b and q SHALL hold at 0 regardless of clk.
REQ-016 After rst_n rises, the first rising clk edge with rst_n high SHALL produce b = 1 and q = 0001.
REQ-017 Asserting reset mid-count SHALL clear b and q to 0 immediately, from any count value; on release, counting restarts from 0.
REQ-018 An edge that coincides with rst_n low SHALL NOT increment the count.

Verification
REQ-019 Scenario: rst_n=0 for one clk period -> b=0000, q=0000 throughout, including before any clk edge.
REQ-020 Scenario: release rst_n, apply 16 edges -> q follows the REQ-013 sequence exactly, and b reads 1..15 then 0.
REQ-021 Scenario: run about 20 edges (beyond one period) -> wrap q 1000->0000 and b 1111->0000; every step has Hamming distance 1 on q.
REQ-022 Scenario: at every sampled edge, check q == b ^ (b>>1) -> no mismatch across a 200-time-unit run at a 10-unit clock period.
REQ-023 Scenario: pull rst_n low mid-period, between edges, with q=0110 -> q=0000 and b=0000 at once; on release the next edge gives q=0001.
REQ-024 Scenario: instantiate with WIDTH=3 -> period of 8, sequence 000, 001, 011, 010, 110, 111, 101, 100, then wrap to 000.

Source files
------------

// File: rtl/gray_counter.sv
// Free-running Gray-code counter.
// A binary count and its Gray image are registered on the same edge.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] q_d;

    // q is encoded from the next binary value so both flops agree after each edge
    always_comb begin
        b_d = b + ONE;
        q_d = b_d ^ (b_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b <= '0;
            q <= '0;
        end else begin
            b <= b_d;
            q <= q_d;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at WIDTH=4 and WIDTH=3.
// Expected Gray sequences are hand-written tables.
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic [3:0] q4;
    logic [2:0] q3;
    logic [3:0] prev4;
    logic [2:0] prev3;

    int vectors = 0;
    int errs    = 0;

    logic [3:0] seq4 [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110,
        4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    logic [2:0] seq3 [8] = '{
        3'b000, 3'b001, 3'b011, 3'b010,
        3'b110, 3'b111, 3'b101, 3'b100
    };

    gray_counter #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q4)
    );

    gray_counter #(.WIDTH(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " q4"}, 32'(q4), 32'd0);
        chk({tag, " b4"}, 32'(u_dut4.b), 32'd0);
        chk({tag, " q3"}, 32'(q3), 32'd0);
        chk({tag, " b3"}, 32'(u_dut3.b), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_zero("async_clear_pre_edge");

        // an edge at t=5 happens with reset low
        @(negedge clk);
        chk_zero("hold_in_reset");
        rst_n = 1'b1;

        for (int i = 1; i <= 20; i++) begin
            prev4 = q4;
            prev3 = q3;
            @(negedge clk);
            chk("seq4_q", 32'(q4), 32'(seq4[i % 16]));
            chk("seq4_b", 32'(u_dut4.b), 32'(i % 16));
            chk("hamming4", 32'($countones(prev4 ^ q4)), 32'd1);
            chk("q4_eq_gray_b",
                32'(q4), 32'(u_dut4.b ^ (u_dut4.b >> 1)));
            chk("seq3_q", 32'(q3), 32'(seq3[i % 8]));
            chk("seq3_b", 32'(u_dut3.b), 32'(i % 8));
            chk("hamming3", 32'($countones(prev3 ^ q3)), 32'd1);
        end

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) @(negedge clk);
        chk("pre_reset_q4", 32'(q4), 32'b0110);
        chk("pre_reset_b4", 32'(u_dut4.b), 32'd4);

        // reset between edges, away from any clk transition
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_mid_count");
        @(posedge clk);
        #1;
        chk_zero("edge_during_reset");

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_q4", 32'(q4), 32'b0001);
        chk("restart_b4", 32'(u_dut4.b), 32'd1);
        chk("restart_q3", 32'(q3), 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
